// File: rtl/reg_read_pkg.sv
// Shared types and default sizes for the LC-3 register-file read unit.
package reg_read_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic [1:0] {IDLE, SHOW, DONE} dump_state_t;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_sel_bypass.sv
// Combinational register select with optional same-cycle write bypass.
// The bypass compare exists only when REG_READ_BYPASS_EN is defined.
module reg_sel_bypass
  import reg_read_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] reg_file,
  input  logic [IDX_W-1:0]           sel,
  input  logic                       ld_reg,
  input  logic [IDX_W-1:0]           dr_sel,
  input  logic [DATA_W-1:0]          bus_data,
  output logic [DATA_W-1:0]          data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] file_word;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
    assign regs[i] = reg_file[i*DATA_W +: DATA_W];
  end

  assign file_word = regs[sel];

`ifdef REG_READ_BYPASS_EN
  // A write landing this cycle wins over the stale file contents.
  assign data = (ld_reg && (dr_sel == sel)) ? bus_data : file_word;
`else
  logic unused_wr;
  assign unused_wr = ^{ld_reg, dr_sel, bus_data};
  assign data      = file_word;
`endif

endmodule

// File: rtl/reg_read_unit.sv
// LC-3 register read side: two registered SR ports and a handshaked R0..R7 dump.
// Build option: define REG_READ_BYPASS_EN to forward same-cycle writes into captures.
module reg_read_unit
  import reg_read_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_REGS*DATA_W-1:0] reg_file,
  input  logic                       ld_reg,
  input  logic [IDX_W-1:0]           dr_sel,
  input  logic [DATA_W-1:0]          bus_data,
  input  logic [IDX_W-1:0]           sr1_sel,
  input  logic [IDX_W-1:0]           sr2_sel,
  output logic [DATA_W-1:0]          sr1_out,
  output logic [DATA_W-1:0]          sr2_out,
  input  logic                       dump_start,
  input  logic                       dump_ready,
  output logic                       dump_valid,
  output logic [IDX_W-1:0]           dump_idx,
  output logic [DATA_W-1:0]          dump_data,
  output logic                       dump_busy,
  output logic                       dump_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dump_state_t       state;
  logic [IDX_W-1:0]  dump_sel_p0;
  logic [DATA_W-1:0] sr1_word_p0;
  logic [DATA_W-1:0] sr2_word_p0;
  logic [DATA_W-1:0] dump_word_p0;

  // Stage p0: index select; the dump looks one register ahead while showing.
  assign dump_sel_p0 = (state == SHOW) ? (dump_idx + IDX_W'(1)) : '0;

  reg_sel_bypass #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_sr1 (
    .reg_file (reg_file),
    .sel      (sr1_sel),
    .ld_reg   (ld_reg),
    .dr_sel   (dr_sel),
    .bus_data (bus_data),
    .data     (sr1_word_p0)
  );

  reg_sel_bypass #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_sr2 (
    .reg_file (reg_file),
    .sel      (sr2_sel),
    .ld_reg   (ld_reg),
    .dr_sel   (dr_sel),
    .bus_data (bus_data),
    .data     (sr2_word_p0)
  );

  reg_sel_bypass #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_dump (
    .reg_file (reg_file),
    .sel      (dump_sel_p0),
    .ld_reg   (ld_reg),
    .dr_sel   (dr_sel),
    .bus_data (bus_data),
    .data     (dump_word_p0)
  );

  // Stage p1: registered SR operands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr1_out <= '0;
      sr2_out <= '0;
    end else begin
      sr1_out <= sr1_word_p0;
      sr2_out <= sr2_word_p0;
    end
  end

  // Stage p1: dump sequencer; the shown word is a snapshot held until accepted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state      <= SHOW;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= dump_word_p0;
          end
        end
        SHOW: begin
          if (dump_valid && dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx  <= dump_sel_p0;
              dump_data <= dump_word_p0;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_unit.sv
// Directed bench for reg_read_unit with queue scoreboards for SR reads and dump words.
module tb_reg_read_unit;
  import reg_read_pkg::*;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

`ifdef REG_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                       Clk;
  logic                       Reset;
  logic [NUM_REGS*DATA_W-1:0] reg_file;
  logic                       ld_reg;
  logic [IDX_W-1:0]           dr_sel;
  logic [DATA_W-1:0]          bus_data;
  logic [IDX_W-1:0]           sr1_sel;
  logic [IDX_W-1:0]           sr2_sel;
  logic [DATA_W-1:0]          sr1_out;
  logic [DATA_W-1:0]          sr2_out;
  logic                       dump_start;
  logic                       dump_ready;
  logic                       dump_valid;
  logic [IDX_W-1:0]           dump_idx;
  logic [DATA_W-1:0]          dump_data;
  logic                       dump_busy;
  logic                       dump_done;

  typedef struct packed {
    word_t s1;
    word_t s2;
  } sr_exp_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    word_t            data;
  } dump_exp_t;

  sr_exp_t   sr_q[$];
  dump_exp_t dq[$];
  int        n_checks = 0;
  int        n_pass   = 0;

  reg_read_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .reg_file   (reg_file),
    .ld_reg     (ld_reg),
    .dr_sel     (dr_sel),
    .bus_data   (bus_data),
    .sr1_sel    (sr1_sel),
    .sr2_sel    (sr2_sel),
    .sr1_out    (sr1_out),
    .sr2_out    (sr2_out),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic word_t get_reg(input int i);
    return reg_file[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_reg(input int i, input word_t v);
    reg_file[i*DATA_W +: DATA_W] = v;
  endtask

  function automatic word_t model_sel(input logic [IDX_W-1:0] sel);
    if (BYP && ld_reg && (dr_sel == sel)) return bus_data;
    return get_reg(int'(sel));
  endfunction

  task automatic sr_step(input string tag);
    sr_exp_t e;
    e.s1 = model_sel(sr1_sel);
    e.s2 = model_sel(sr2_sel);
    sr_q.push_back(e);
    step();
    e = sr_q.pop_front();
    chk({tag, "_sr1"}, 32'(sr1_out), 32'(e.s1));
    chk({tag, "_sr2"}, 32'(sr2_out), 32'(e.s2));
  endtask

  task automatic run_dump(input string tag, input int stall_at, input int stall_n,
                          input bit hold_start, input bit rewrite);
    int words, dones, gaps, stalled, cyc;
    dump_exp_t e;
    words = 0; dones = 0; gaps = 0; stalled = 0; cyc = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      e.idx  = IDX_W'(i);
      e.data = get_reg(i);
      dq.push_back(e);
    end
    dump_start = 1'b1;
    dump_ready = 1'b1;
    step();
    if (!hold_start) dump_start = 1'b0;
    chk({tag, "_busy_start"}, 32'(dump_busy), 32'd1);
    while (dones == 0 && cyc < 64) begin
      if (dump_done) begin
        dones++;
        chk({tag, "_valid_in_done"}, 32'(dump_valid), 32'd0);
      end else if (!dump_valid) begin
        gaps++;
      end else if (int'(dump_idx) == stall_at && stalled < stall_n) begin
        dump_ready = 1'b0;
        if (rewrite && stalled == 0) set_reg(stall_at, 16'h2222);
        stalled++;
        if (dq.size() > 0) chk({tag, "_stall_data"}, 32'(dump_data), 32'(dq[0].data));
        else chk({tag, "_stall_q"}, 32'(dq.size()), 32'd1);
      end else begin
        dump_ready = 1'b1;
        if (dq.size() > 0) begin
          e = dq.pop_front();
          chk({tag, "_idx"}, 32'(dump_idx), 32'(e.idx));
          chk({tag, "_data"}, 32'(dump_data), 32'(e.data));
        end
        words++;
      end
      if (dones == 0) step();
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(dones), 32'd1);
    chk({tag, "_words"}, 32'(words), 32'(NUM_REGS));
    chk({tag, "_gaps"}, 32'(gaps), 32'd0);
    chk({tag, "_q_empty"}, 32'(dq.size()), 32'd0);
    dq.delete();
    dump_ready = 1'b1;
    step();
    chk({tag, "_done_1cyc"}, 32'(dump_done), 32'd0);
    chk({tag, "_busy_clear"}, 32'(dump_busy), 32'd0);
    chk({tag, "_valid_idle"}, 32'(dump_valid), 32'd0);
    step();
    if (hold_start) begin
      chk({tag, "_restart_valid"}, 32'(dump_valid), 32'd1);
      chk({tag, "_restart_idx"}, 32'(dump_idx), 32'd0);
      chk({tag, "_restart_busy"}, 32'(dump_busy), 32'd1);
    end else begin
      chk({tag, "_stay_idle"}, 32'(dump_valid), 32'd0);
    end
  endtask

  initial begin
    int  cyc;
    bit  seen_done;
    Reset      = 1'b1;
    ld_reg     = 1'b0;
    dr_sel     = '0;
    bus_data   = '0;
    sr1_sel    = 3'd3;
    sr2_sel    = 3'd5;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) set_reg(i, word_t'(16'h1000 + i));

    step();
    dump_start = 1'b1;
    step();
    chk("rst_sr1", 32'(sr1_out), 32'd0);
    chk("rst_sr2", 32'(sr2_out), 32'd0);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_idx", 32'(dump_idx), 32'd0);
    chk("rst_data", 32'(dump_data), 32'd0);
    dump_start = 1'b0;
    Reset      = 1'b0;

    sr_step("rd35");
    chk("rd35_const1", 32'(sr1_out), 32'h1003);
    chk("rd35_const2", 32'(sr2_out), 32'h1005);

    ld_reg   = 1'b1;
    dr_sel   = 3'd3;
    bus_data = 16'hBEEF;
    sr1_sel  = 3'd3;
    sr2_sel  = 3'd3;
    sr_step("byp");
    chk("byp_const1", 32'(sr1_out), BYP ? 32'hBEEF : 32'h1003);
    chk("byp_const2", 32'(sr2_out), BYP ? 32'hBEEF : 32'h1003);
    ld_reg = 1'b0;
    sr_step("after_wr");

    ld_reg   = 1'b1;
    dr_sel   = 3'd7;
    bus_data = 16'h7777;
    sr1_sel  = 3'd0;
    sr2_sel  = 3'd7;
    sr_step("byp_one");
    dr_sel  = 3'd4;
    sr1_sel = 3'd2;
    sr2_sel = 3'd6;
    sr_step("no_match");
    ld_reg = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sr1_sel = IDX_W'(i);
      sr2_sel = IDX_W'(NUM_REGS - 1 - i);
      sr_step("sweep");
    end

    run_dump("dump_full", -1, 0, 1'b0, 1'b0);
    run_dump("dump_stall", 2, 4, 1'b0, 1'b1);
    set_reg(2, 16'h1002);
    run_dump("dump_hold", -1, 0, 1'b1, 1'b0);
    dump_start = 1'b0;

    dump_ready = 1'b1;
    cyc = 0;
    while (dump_idx != 3'd5 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rst_mid_idx5", 32'(dump_idx), 32'd5);
    Reset = 1'b1;
    step();
    chk("rst_mid_valid", 32'(dump_valid), 32'd0);
    chk("rst_mid_idx", 32'(dump_idx), 32'd0);
    chk("rst_mid_busy", 32'(dump_busy), 32'd0);
    chk("rst_mid_done", 32'(dump_done), 32'd0);
    chk("rst_mid_data", 32'(dump_data), 32'd0);
    Reset     = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dump_done) seen_done = 1'b1;
    end
    chk("rst_mid_no_done", 32'(seen_done), 32'd0);
    chk("rst_mid_idle", 32'(dump_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
